// File: rtl/data_mem_ctrl.sv
// Single-port word memory with RISC-V byte/half/word load-store semantics.
// Latency: request accepted on edge N, response valid after edge N+1 (IDLE/ACCESS/RESP, 3 cycles minimum).
// Backpressure: req_ready only in IDLE; RESP holds its outputs until rsp_ready.
module data_mem_ctrl #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH) << 2;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]  state;
    logic        r_we;
    logic [2:0]  r_funct;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic [31:0] mem [DEPTH];

    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          funct_ok;
    logic          misalign;
    logic          acc_err;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [31:0]   ld_data;

    always_comb begin
        off      = r_addr - BASE_ADDR;
        idx      = off[AW+1:2];
        in_range = (r_addr >= BASE_ADDR) && ({1'b0, off} < MEM_BYTES);
        if (r_we)
            funct_ok = (r_funct < 3'b011);
        else
            funct_ok = (r_funct[1:0] != 2'b11) && (r_funct != 3'b110);
        misalign = ((r_funct[1:0] == 2'b01) && r_addr[0]) ||
                   ((r_funct[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
        acc_err  = !funct_ok || misalign || !in_range;

        // Store data is replicated across lanes so the byte enables alone pick the target bytes.
        wr_be   = 4'b0000;
        wr_data = r_wdata;
        case (r_funct[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << r_addr[1:0];
                wr_data = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = r_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{r_wdata[15:0]}};
            end
            2'b10: wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase

        rd_word  = mem[idx];
        rd_shift = rd_word >> {r_addr[1:0], 3'b000};
        case (r_funct)
            3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  ld_data = {24'h0, rd_shift[7:0]};
            3'b101:  ld_data = {16'h0, rd_shift[15:0]};
            default: ld_data = rd_shift;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            r_we      <= 1'b0;
            r_funct   <= 3'b000;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_funct <= req_funct;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    rsp_err   <= acc_err;
                    rsp_rdata <= (r_we || acc_err) ? 32'h0 : ld_data;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // State is forced to IDLE asynchronously, so a reset during ACCESS suppresses the write.
    always_ff @(posedge clk) begin
        if (state == ACCESS && r_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b])
                    mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: load/store lanes, errors, backpressure and reset mid-access.
module tb_data_mem_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    data_mem_ctrl #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct (req_funct),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic we, input logic [2:0] funct,
                           input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_funct = funct;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    // Called 1 time unit after a rising edge with the FSM in IDLE; returns in IDLE.
    task automatic txn(input string tag, input logic we, input logic [2:0] funct,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
        check({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
        present(we, funct, addr, wdata);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, " rsp_valid access"}, 32'(rsp_valid), 32'd0);
        check({tag, " req_ready access"}, 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, " rdata"}, rsp_rdata, exp_rdata);
        check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, " back idle"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_funct = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rdata", rsp_rdata, 32'h0);
        check("rst err", 32'(rsp_err), 32'd0);
        reset = 1'b1;

        // First request goes in on the first edge after deassertion.
        txn("sw0", 1'b1, F_W, 32'h0000_0000, 32'hCAFE_F00D, 32'h0, 1'b0);
        txn("sw10", 1'b1, F_W, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
        txn("lw10", 1'b0, F_W, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);

        txn("sb13", 1'b1, F_B, 32'h0000_0013, 32'h0000_0080, 32'h0, 1'b0);
        txn("lb13", 1'b0, F_B, 32'h0000_0013, 32'h0, 32'hFFFF_FF80, 1'b0);
        txn("lbu13", 1'b0, F_BU, 32'h0000_0013, 32'h0, 32'h0000_0080, 1'b0);
        txn("lw10 after sb", 1'b0, F_W, 32'h0000_0010, 32'h0, 32'h80AD_BEEF, 1'b0);

        txn("sw14 zero", 1'b1, F_W, 32'h0000_0014, 32'h0, 32'h0, 1'b0);
        txn("sh16", 1'b1, F_H, 32'h0000_0016, 32'hFFFF_1234, 32'h0, 1'b0);
        txn("lhu16", 1'b0, F_HU, 32'h0000_0016, 32'h0, 32'h0000_1234, 1'b0);
        txn("lw14", 1'b0, F_W, 32'h0000_0014, 32'h0, 32'h1234_0000, 1'b0);
        txn("lh15 misaligned", 1'b0, F_H, 32'h0000_0015, 32'h0, 32'h0, 1'b1);
        txn("sb15", 1'b1, F_B, 32'h0000_0015, 32'h0000_00AB, 32'h0, 1'b0);
        txn("lw14 after sb15", 1'b0, F_W, 32'h0000_0014, 32'h0, 32'h1234_AB00, 1'b0);
        txn("lb15", 1'b0, F_B, 32'h0000_0015, 32'h0, 32'hFFFF_FFAB, 1'b0);
        txn("sh14", 1'b1, F_H, 32'h0000_0014, 32'h0000_8001, 32'h0, 1'b0);
        txn("lh14", 1'b0, F_H, 32'h0000_0014, 32'h0, 32'hFFFF_8001, 1'b0);
        txn("lw14 after sh14", 1'b0, F_W, 32'h0000_0014, 32'h0, 32'h1234_8001, 1'b0);

        // Out-of-range store must not alias onto word 0.
        txn("sw oor", 1'b1, F_W, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0, 1'b1);
        txn("lw0 unchanged", 1'b0, F_W, 32'h0000_0000, 32'h0, 32'hCAFE_F00D, 1'b0);
        txn("lw oor", 1'b0, F_W, 32'h0000_1004, 32'h0, 32'h0, 1'b1);
        txn("sw last", 1'b1, F_W, 32'h0000_0FFC, 32'h5A5A_5A5A, 32'h0, 1'b0);
        txn("lw last", 1'b0, F_W, 32'h0000_0FFC, 32'h0, 32'h5A5A_5A5A, 1'b0);
        txn("load funct 011", 1'b0, 3'b011, 32'h0000_0010, 32'h0, 32'h0, 1'b1);
        txn("load funct 110", 1'b0, 3'b110, 32'h0000_0010, 32'h0, 32'h0, 1'b1);
        txn("store funct 011", 1'b1, 3'b011, 32'h0000_0010, 32'h0, 32'h0, 1'b1);
        txn("store funct 100", 1'b1, 3'b100, 32'h0000_0010, 32'h0, 32'h0, 1'b1);
        txn("lw12 misaligned", 1'b0, F_W, 32'h0000_0012, 32'h0, 32'h0, 1'b1);
        txn("sh11 misaligned", 1'b1, F_H, 32'h0000_0011, 32'h0000_5555, 32'h0, 1'b1);
        txn("lw10 after errs", 1'b0, F_W, 32'h0000_0010, 32'h0, 32'h80AD_BEEF, 1'b0);

        // Backpressure: response held for 5 cycles while a competing request is ignored.
        present(1'b0, F_W, 32'h0000_0010, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("bp rsp_valid", 32'(rsp_valid), 32'd1);
        present(1'b1, F_W, 32'h0000_0010, 32'h0000_0000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp hold rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp hold rdata", rsp_rdata, 32'h80AD_BEEF);
            check("bp hold err", 32'(rsp_err), 32'd0);
            check("bp hold req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp release req_ready", 32'(req_ready), 32'd1);
        check("bp release rsp_valid", 32'(rsp_valid), 32'd0);
        txn("lw10 after bp", 1'b0, F_W, 32'h0000_0010, 32'h0, 32'h80AD_BEEF, 1'b0);

        // Reset in the middle of a store's ACCESS cycle.
        txn("sw20", 1'b1, F_W, 32'h0000_0020, 32'h1111_1111, 32'h0, 1'b0);
        txn("lw20", 1'b0, F_W, 32'h0000_0020, 32'h0, 32'h1111_1111, 1'b0);
        present(1'b1, F_W, 32'h0000_0020, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("mid access req_ready", 32'(req_ready), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("arst req_ready", 32'(req_ready), 32'd1);
        check("arst rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst rdata", rsp_rdata, 32'h0);
        check("arst err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;
        check("arst held rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        txn("lw20 after rst", 1'b0, F_W, 32'h0000_0020, 32'h0, 32'h1111_1111, 1'b0);
        txn("lw10 after rst", 1'b0, F_W, 32'h0000_0010, 32'h0, 32'h80AD_BEEF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
